ram_fifo_ctrl: RTL and testbench

//  Upstream controller for the 8x8 single-port ram block. Turns a valid/ready

---
 rtl/ram_fifo_ctrl.sv | 113 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for an 8x8 single-port RAM: byte stream in, RAM write/read
// cycles, registered valid/ready output. Reads are favoured over writes.
module ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              ram_w,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, RD_ADDR, RD_DATA} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic [ADDR_W:0]     count_q;
  logic                ram_w_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_data_in_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;

  logic [ADDR_W-1:0]   wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_d;
  logic                full_d;
  logic                rd_need_d;
  logic                in_ready_d;

  // Status terms depend on registers only, so in_ready has no input-to-output path.
  assign wr_ptr_d   = wr_ptr_q + 1'b1;
  assign rd_ptr_d   = rd_ptr_q + 1'b1;
  assign full_d     = (count_q == DEPTH_C);
  assign rd_need_d  = !out_valid_q && (count_q != '0);
  assign in_ready_d = (state_q == IDLE) && !full_d && !rd_need_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ram_w_q       <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (rd_need_d) begin
            ram_addr_q <= rd_ptr_q;
            ram_w_q    <= 1'b0;
            state_q    <= RD_ADDR;
          end else if (in_valid && in_ready_d) begin
            ram_addr_q    <= wr_ptr_q;
            ram_data_in_q <= in_data;
            ram_w_q       <= 1'b1;
            state_q       <= WRITE;
          end
        end
        WRITE: begin
          ram_w_q  <= 1'b0;
          wr_ptr_q <= wr_ptr_d;
          count_q  <= count_q + 1'b1;
          state_q  <= IDLE;
        end
        // One idle address cycle lets either a combinational or registered-read RAM settle.
        RD_ADDR: begin
          ram_w_q <= 1'b0;
          state_q <= RD_DATA;
        end
        RD_DATA: begin
          out_data_q  <= ram_data_out;
          out_valid_q <= 1'b1;
          rd_ptr_q    <= rd_ptr_d;
          count_q     <= count_q - 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_d;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign ram_w       = ram_w_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_data_in_q;
  assign count       = count_q;
  assign full        = full_d;
  assign empty       = (count_q == '0) && !out_valid_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM, scoreboard for RAM writes and
// output words, a table of fill-level vectors plus hand-written corner sequences.
module tb_ram_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              ram_w;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_w(ram_w), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out),
    .count(count), .full(full), .empty(empty)
  );

  // Single-port RAM with registered read
  logic [DATA_W-1:0] mem [0:7];
  always @(posedge clk) begin
    if (ram_w) mem[ram_addr] <= ram_data_in;
    ram_data_out <= mem[ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [DATA_W-1:0]        exp_q[$];
  logic [ADDR_W+DATA_W-1:0] wr_q[$];
  logic [ADDR_W-1:0]        wr_addr_ctr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change only at posedge+1, so at the negedge every signal is what the next edge sees.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      wr_q.delete();
      wr_addr_ctr = '0;
    end else begin
      if (ram_w) begin
        if (wr_q.size() == 0) begin
          check("ram_w_unexpected", 32'(wr_q.size()), 1);
        end else begin
          logic [ADDR_W+DATA_W-1:0] w;
          w = wr_q.pop_front();
          check("ram_write_addr_data", {ram_addr, ram_data_in}, w);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        wr_q.push_back({wr_addr_ctr, in_data});
        wr_addr_ctr = wr_addr_ctr + 1'b1;
        $display("push data=%0d addr=%0d", in_data, wr_addr_ctr - 1'b1);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 32'(exp_q.size()), 1);
        end else begin
          logic [DATA_W-1:0] e;
          e = exp_q.pop_front();
          check("out_data_order", out_data, e);
        end
        $display("pop  data=%0d", out_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // Offers one word and returns at posedge+1 after the accepting edge.
  task automatic push(input logic [DATA_W-1:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("push_accept_timeout", ok, 1);
    step();
    in_valid = 1'b0;
  endtask

  typedef struct {
    int                n;
    logic [DATA_W-1:0] base;
    logic [ADDR_W:0]   exp_count;
    logic              exp_full;
    logic              exp_empty;
    logic              exp_in_ready;
    logic              exp_out_valid;
    logic [DATA_W-1:0] exp_out_data;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1, 8'h11, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
    vecs[2] = '{3, 8'h40, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40};
    vecs[3] = '{8, 8'h80, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80};
    vecs[4] = '{9, 8'hC0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC0};

    // Reset state while rst is held low
    #2;
    check("rst_ram_w", ram_w, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_out_data", out_data, 0);
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_empty", empty, 1);
    step();

    // Reset mid-stream while a write is in flight
    out_ready = 1'b0;
    push(8'h5A);
    push(8'h5B);
    check("write_state_ram_w", ram_w, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_ram_w", ram_w, 0);
    check("async_out_valid", out_valid, 0);
    check("async_count", count, 0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rel2_in_ready", in_ready, 1);
    check("rel2_empty", empty, 1);
    step();

    // Fresh push lands at addr 0; out_valid rises 4 clocks after the handshake edge
    out_ready = 1'b1;
    push(8'hA7);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("latency_out_valid", out_valid, (k == 5));
    end
    step();
    repeat (4) step();

    // Three words held back, then drained in order
    do_reset();
    push(8'd66);
    push(8'd123);
    push(8'd234);
    repeat (10) step();
    @(negedge clk);
    check("t2_out_data", out_data, 66);
    check("t2_out_valid", out_valid, 1);
    check("t2_count", count, 2);
    step();
    out_ready = 1'b1;
    repeat (30) step();
    @(negedge clk);
    check("t3_out_valid", out_valid, 0);
    check("t3_empty", empty, 1);
    check("t3_sb_left", 32'(exp_q.size()), 0);
    step();

    // Fill-level table
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) push(vecs[v].base + 8'(i));
      repeat (12) step();
      @(negedge clk);
      check("vec_count", count, vecs[v].exp_count);
      check("vec_full", full, vecs[v].exp_full);
      check("vec_empty", empty, vecs[v].exp_empty);
      check("vec_in_ready", in_ready, vecs[v].exp_in_ready);
      check("vec_out_valid", out_valid, vecs[v].exp_out_valid);
      check("vec_out_data", out_data, vecs[v].exp_out_data);
      step();
    end

    // Full stall: word 10 waits until a single pop frees a slot
    do_reset();
    for (int i = 1; i <= 9; i++) push(8'(i));
    in_valid = 1'b1;
    in_data  = 8'd10;
    repeat (6) step();
    @(negedge clk);
    check("t4_in_ready", in_ready, 0);
    check("t4_full", full, 1);
    check("t4_count", count, 8);
    check("t4_out_data", out_data, 1);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      check("t4_accept_10", ok, 1);
      step();
      in_valid = 1'b0;
    end
    repeat (8) step();
    @(negedge clk);
    check("t4_refill_data", out_data, 2);
    check("t4_refill_count", count, 8);
    step();
    out_ready = 1'b1;
    repeat (60) step();
    @(negedge clk);
    check("t4_drained", 32'(exp_q.size()), 0);
    step();

    // Continuous stream across both pointer wraps
    do_reset();
    out_ready = 1'b1;
    begin
      int n0;
      n0 = n_out;
      for (int i = 0; i < 20; i++) push(8'(i));
      repeat (40) step();
      @(negedge clk);
      check("t5_out_count", 32'(n_out - n0), 20);
      check("t5_sb_left", 32'(exp_q.size()), 0);
      check("t5_wr_left", 32'(wr_q.size()), 0);
      check("t5_empty", empty, 1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
